// File: rtl/sdram_host_sequencer.sv
// SDRAM host sequencer: arbitrates host read/write requests against periodic
// auto-refresh, drives a single-command controller interface and returns one
// completion pulse per host access.
module sdram_host_sequencer #(
  parameter int unsigned REF_PERIOD   = 1560,
  parameter int unsigned REF_MAX_PEND = 8
) (
  input  logic        clk_200MHz_i,
  input  logic        reset_i,
  // host request
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [24:0] req_addr_i,
  input  logic [15:0] req_data_i,
  input  logic        req_ub_i,
  input  logic        req_lb_i,
  // host completion
  output logic        rsp_valid_o,
  output logic        rsp_we_o,
  output logic [15:0] rsp_data_o,
  // controller status
  input  logic        ctl_ready_i,
  input  logic        ctl_done_i,
  input  logic [15:0] ctl_data_i,
  // controller command
  output logic        ctl_rw_o,
  output logic        ctl_we_o,
  output logic        ctl_refresh_o,
  output logic [24:0] ctl_addr_o,
  output logic [15:0] ctl_data_o,
  output logic        ctl_ub_o,
  output logic        ctl_lb_o,
  // refresh health
  output logic        ref_ovf_o
);

  localparam int unsigned TW = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;
  localparam int unsigned PW = $clog2(REF_MAX_PEND + 1);
  localparam logic [TW-1:0] TIMER_RELOAD = TW'(REF_PERIOD - 1);
  localparam logic [PW-1:0] PEND_MAX     = PW'(REF_MAX_PEND);

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_ACCESS,
    ST_REFRESH
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic          timer_run;
  logic          tick;
  logic          ref_done;
  logic [PW-1:0] pend_cnt;
  logic          acc_we;

  assign tick        = timer_run && (timer == '0);
  assign ref_done    = (state == ST_REFRESH) && ctl_done_i;
  assign req_ready_o = (state == ST_IDLE) && (pend_cnt == '0);

  // Refresh interval timer: armed when the controller finishes init, then free-running
  always_ff @(posedge clk_200MHz_i or posedge reset_i) begin
    if (reset_i) begin
      timer_run <= 1'b0;
      timer     <= '0;
    end else if (state == ST_INIT) begin
      if (ctl_ready_i) begin
        timer_run <= 1'b1;
        timer     <= TIMER_RELOAD;
      end
    end else if (timer_run) begin
      timer <= tick ? TIMER_RELOAD : timer - 1'b1;
    end
  end

  // Pending-refresh bookkeeping; a tick coinciding with a completed refresh cancels out
  always_ff @(posedge clk_200MHz_i or posedge reset_i) begin
    if (reset_i) begin
      pend_cnt  <= '0;
      ref_ovf_o <= 1'b0;
    end else if (tick && !ref_done) begin
      if (pend_cnt == PEND_MAX) begin
        ref_ovf_o <= 1'b1;
      end else begin
        pend_cnt <= pend_cnt + 1'b1;
      end
    end else if (!tick && ref_done && (pend_cnt != '0)) begin
      pend_cnt <= pend_cnt - 1'b1;
    end
  end

  // Main sequencer with registered controller command and host completion outputs
  always_ff @(posedge clk_200MHz_i or posedge reset_i) begin
    if (reset_i) begin
      state         <= ST_INIT;
      acc_we        <= 1'b0;
      rsp_valid_o   <= 1'b0;
      rsp_we_o      <= 1'b0;
      rsp_data_o    <= '0;
      ctl_rw_o      <= 1'b0;
      ctl_we_o      <= 1'b1;
      ctl_refresh_o <= 1'b0;
      ctl_addr_o    <= '0;
      ctl_data_o    <= '0;
      ctl_ub_o      <= 1'b0;
      ctl_lb_o      <= 1'b0;
    end else begin
      rsp_valid_o <= 1'b0;
      case (state)
        ST_INIT: begin
          if (ctl_ready_i) begin
            state <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (pend_cnt != '0) begin
            state         <= ST_REFRESH;
            ctl_refresh_o <= 1'b1;
          end else if (req_valid_i) begin
            state      <= ST_ACCESS;
            acc_we     <= req_we_i;
            ctl_rw_o   <= 1'b1;
            ctl_we_o   <= ~req_we_i;
            ctl_addr_o <= req_addr_i;
            ctl_data_o <= req_data_i;
            ctl_ub_o   <= req_ub_i;
            ctl_lb_o   <= req_lb_i;
          end
        end
        ST_ACCESS: begin
          if (ctl_done_i) begin
            state       <= ST_IDLE;
            ctl_rw_o    <= 1'b0;
            ctl_we_o    <= 1'b1;
            rsp_valid_o <= 1'b1;
            rsp_we_o    <= acc_we;
            rsp_data_o  <= acc_we ? '0 : ctl_data_i;
          end
        end
        ST_REFRESH: begin
          if (ctl_done_i) begin
            state         <= ST_IDLE;
            ctl_refresh_o <= 1'b0;
          end
        end
        default: begin
          state <= ST_INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_host_sequencer.sv
// Directed bench for sdram_host_sequencer with a controller model that
// answers each command with done on the fifth cycle it is presented.
`timescale 1ns/1ps
module tb_sdram_host_sequencer;

  logic        clk_200MHz_i = 1'b0;
  logic        reset_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [24:0] req_addr_i;
  logic [15:0] req_data_i;
  logic        req_ub_i;
  logic        req_lb_i;
  logic        rsp_valid_o;
  logic        rsp_we_o;
  logic [15:0] rsp_data_o;
  logic        ctl_ready_i;
  logic        ctl_done_i = 1'b0;
  logic [15:0] ctl_data_i;
  logic        ctl_rw_o;
  logic        ctl_we_o;
  logic        ctl_refresh_o;
  logic [24:0] ctl_addr_o;
  logic [15:0] ctl_data_o;
  logic        ctl_ub_o;
  logic        ctl_lb_o;
  logic        ref_ovf_o;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  int unsigned mcnt        = 0;
  logic        ref_done_en = 1'b1;

  sdram_host_sequencer #(
    .REF_PERIOD  (16),
    .REF_MAX_PEND(8)
  ) dut (
    .clk_200MHz_i (clk_200MHz_i),
    .reset_i      (reset_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_we_i     (req_we_i),
    .req_addr_i   (req_addr_i),
    .req_data_i   (req_data_i),
    .req_ub_i     (req_ub_i),
    .req_lb_i     (req_lb_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_we_o     (rsp_we_o),
    .rsp_data_o   (rsp_data_o),
    .ctl_ready_i  (ctl_ready_i),
    .ctl_done_i   (ctl_done_i),
    .ctl_data_i   (ctl_data_i),
    .ctl_rw_o     (ctl_rw_o),
    .ctl_we_o     (ctl_we_o),
    .ctl_refresh_o(ctl_refresh_o),
    .ctl_addr_o   (ctl_addr_o),
    .ctl_data_o   (ctl_data_o),
    .ctl_ub_o     (ctl_ub_o),
    .ctl_lb_o     (ctl_lb_o),
    .ref_ovf_o    (ref_ovf_o)
  );

  always #2.5 clk_200MHz_i = ~clk_200MHz_i;

  // Controller model: done on the 5th rising edge a command is seen; refresh answers can be muted
  always @(negedge clk_200MHz_i) begin
    if (reset_i || !(ctl_rw_o || (ctl_refresh_o && ref_done_en))) begin
      mcnt       = 0;
      ctl_done_i = 1'b0;
    end else begin
      mcnt       = mcnt + 1;
      ctl_done_i = (mcnt == 5);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_200MHz_i);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req_ready"}, req_ready_o, 0);
    chk({tag, "_rsp_valid"}, rsp_valid_o, 0);
    chk({tag, "_rsp_we"},    rsp_we_o, 0);
    chk({tag, "_rsp_data"},  rsp_data_o, 0);
    chk({tag, "_rw"},        ctl_rw_o, 0);
    chk({tag, "_we"},        ctl_we_o, 1);
    chk({tag, "_refresh"},   ctl_refresh_o, 0);
    chk({tag, "_addr"},      ctl_addr_o, 0);
    chk({tag, "_data"},      ctl_data_o, 0);
    chk({tag, "_ub"},        ctl_ub_o, 0);
    chk({tag, "_lb"},        ctl_lb_o, 0);
    chk({tag, "_ovf"},       ref_ovf_o, 0);
  endtask

  initial begin
    reset_i     = 1'b1;
    ctl_ready_i = 1'b0;
    req_valid_i = 1'b0;
    req_we_i    = 1'b0;
    req_addr_i  = '0;
    req_data_i  = '0;
    req_ub_i    = 1'b0;
    req_lb_i    = 1'b0;
    ctl_data_i  = 16'h1234;

    step(3);
    chk_reset("rst");
    reset_i = 1'b0;

    // controller not ready: request must not be accepted
    req_valid_i = 1'b1;
    req_addr_i  = 25'h0000601;
    for (int i = 0; i < 50; i++) begin
      step(1);
      chk("init_ready", req_ready_o, 0);
      chk("init_rw", ctl_rw_o, 0);
    end
    ctl_ready_i = 1'b1;
    req_valid_i = 1'b0;
    step(1);                                   // R: enter idle
    chk("idle_ready", req_ready_o, 1);
    ctl_ready_i = 1'b0;                        // ignored from here on

    // read
    req_valid_i = 1'b1;
    req_we_i    = 1'b0;
    step(1);                                   // R+1
    chk("rd_rw", ctl_rw_o, 1);
    chk("rd_we", ctl_we_o, 1);
    chk("rd_addr", ctl_addr_o, 32'h0000601);
    chk("rd_ready", req_ready_o, 0);
    req_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin          // R+2..R+5
      step(1);
      chk("rd_hold_rw", ctl_rw_o, 1);
      chk("rd_hold_we", ctl_we_o, 1);
      chk("rd_hold_rsp", rsp_valid_o, 0);
    end
    step(1);                                   // R+6
    chk("rd_rsp_valid", rsp_valid_o, 1);
    chk("rd_rsp_we", rsp_we_o, 0);
    chk("rd_rsp_data", rsp_data_o, 32'h1234);
    chk("rd_rw_drop", ctl_rw_o, 0);
    chk("rd_ready_back", req_ready_o, 1);

    // write
    req_valid_i = 1'b1;
    req_we_i    = 1'b1;
    req_data_i  = 16'hADCD;
    req_ub_i    = 1'b1;
    req_lb_i    = 1'b0;
    step(1);                                   // R+7
    chk("rd_rsp_pulse", rsp_valid_o, 0);
    chk("wr_rw", ctl_rw_o, 1);
    chk("wr_we", ctl_we_o, 0);
    chk("wr_data", ctl_data_o, 32'hADCD);
    chk("wr_ub", ctl_ub_o, 1);
    chk("wr_lb", ctl_lb_o, 0);
    req_valid_i = 1'b0;
    req_data_i  = 16'h0000;
    req_ub_i    = 1'b0;
    req_lb_i    = 1'b1;
    for (int i = 0; i < 4; i++) begin          // R+8..R+11
      step(1);
      chk("wr_hold_rw", ctl_rw_o, 1);
      chk("wr_hold_we", ctl_we_o, 0);
      chk("wr_hold_data", ctl_data_o, 32'hADCD);
      chk("wr_hold_ub", ctl_ub_o, 1);
      chk("wr_hold_lb", ctl_lb_o, 0);
    end
    step(1);                                   // R+12
    chk("wr_rsp_valid", rsp_valid_o, 1);
    chk("wr_rsp_we", rsp_we_o, 1);
    chk("wr_rsp_data", rsp_data_o, 0);
    chk("wr_rw_drop", ctl_rw_o, 0);

    // first refresh tick lands at R+16; a request raised then waits for it
    step(3);                                   // R+15
    chk("pre_tick_ready", req_ready_o, 1);
    chk("pre_tick_pend", dut.pend_cnt, 0);
    step(1);                                   // R+16
    chk("tick_pend", dut.pend_cnt, 1);
    chk("tick_ready", req_ready_o, 0);
    req_valid_i = 1'b1;
    req_we_i    = 1'b0;
    req_addr_i  = 25'h155AA55;
    step(1);                                   // R+17
    chk("ref_refresh", ctl_refresh_o, 1);
    chk("ref_rw", ctl_rw_o, 0);
    chk("ref_ready", req_ready_o, 0);
    for (int i = 0; i < 4; i++) begin          // R+18..R+21
      step(1);
      chk("ref_hold", ctl_refresh_o, 1);
      chk("ref_hold_rw", ctl_rw_o, 0);
    end
    step(1);                                   // R+22
    chk("ref_drop", ctl_refresh_o, 0);
    chk("ref_pend0", dut.pend_cnt, 0);
    chk("ref_ready_back", req_ready_o, 1);
    chk("ref_rw_still0", ctl_rw_o, 0);
    step(1);                                   // R+23
    chk("wait_rd_rw", ctl_rw_o, 1);
    chk("wait_rd_addr", ctl_addr_o, 32'h155AA55);
    req_valid_i = 1'b0;
    ref_done_en = 1'b0;
    step(5);                                   // R+28
    chk("wait_rd_rsp", rsp_valid_o, 1);
    chk("wait_rd_data", rsp_data_o, 32'h1234);

    // refreshes never complete: nine ticks saturate the count and set overflow
    step(4);                                   // R+32
    chk("ovf_pend1", dut.pend_cnt, 1);
    step(1);                                   // R+33
    chk("ovf_refresh", ctl_refresh_o, 1);
    step(126);                                 // R+159
    chk("ovf_pend8", dut.pend_cnt, 8);
    chk("ovf_not_yet", ref_ovf_o, 0);
    step(1);                                   // R+160
    chk("ovf_set", ref_ovf_o, 1);
    chk("ovf_pend_sat", dut.pend_cnt, 8);
    step(20);                                  // R+180
    chk("ovf_sticky", ref_ovf_o, 1);
    chk("ovf_pend_hold", dut.pend_cnt, 8);
    chk("ovf_excl_rw", ctl_rw_o, 0);
    chk("ovf_refresh_held", ctl_refresh_o, 1);

    // asynchronous reset clears overflow without a clock edge
    reset_i = 1'b1;
    #1;
    chk("arst_ovf", ref_ovf_o, 0);
    chk("arst_refresh", ctl_refresh_o, 0);
    chk("arst_pend", dut.pend_cnt, 0);
    step(1);
    reset_i     = 1'b0;
    ref_done_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("rinit_ready", req_ready_o, 0);
      chk("rinit_refresh", ctl_refresh_o, 0);
    end
    ctl_ready_i = 1'b1;
    step(1);                                   // R2
    chk("r2_ready", req_ready_o, 1);
    req_valid_i = 1'b1;
    req_we_i    = 1'b1;
    req_addr_i  = 25'h1FFFFFF;
    req_data_i  = 16'h5A5A;
    req_ub_i    = 1'b0;
    req_lb_i    = 1'b1;
    step(1);                                   // R2+1
    chk("r2_rw", ctl_rw_o, 1);
    chk("r2_addr", ctl_addr_o, 32'h1FFFFFF);
    chk("r2_lb", ctl_lb_o, 1);
    req_valid_i = 1'b0;
    step(2);                                   // R2+3, mid-access
    chk("r2_mid_rw", ctl_rw_o, 1);
    ctl_ready_i = 1'b0;
    reset_i     = 1'b1;
    #1;
    chk_reset("midacc");
    step(1);
    chk("midacc_rsp", rsp_valid_o, 0);
    reset_i = 1'b0;
    req_valid_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(1);
      chk("post_rsp", rsp_valid_o, 0);
      chk("post_rw", ctl_rw_o, 0);
      chk("post_ready", req_ready_o, 0);
    end
    ctl_ready_i = 1'b1;
    step(1);                                   // R3
    chk("r3_ready", req_ready_o, 1);
    step(1);                                   // R3+1
    chk("r3_rw", ctl_rw_o, 1);
    chk("r3_we", ctl_we_o, 0);
    req_valid_i = 1'b0;
    step(4);                                   // R3+5
    chk("r3_hold_rw", ctl_rw_o, 1);
    chk("r3_no_rsp", rsp_valid_o, 0);
    step(1);                                   // R3+6
    chk("r3_rsp_valid", rsp_valid_o, 1);
    chk("r3_rsp_we", rsp_we_o, 1);
    chk("r3_rsp_data", rsp_data_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
